uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver; next generation of the fixed 8N1 receiver.

---
 rtl/uart_rx_cfg.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver.
//   Configurable data width (5..9, LSB first), parity (none/even/odd) and
//   1 or 2 stop bits. The input passes through a 2-flop synchroniser, and a
//   start bit must still be low at its mid-point or the edge is treated as a glitch.
//   Parity, framing and break conditions are reported alongside each frame.
// Ports:
//   i_Clock      system clock, rising edge
//   i_Rst_n      asynchronous active-low reset
//   i_Rx_Serial  raw serial line, idle high, asynchronous to i_Clock
//   o_Rx_DV      one-cycle pulse: frame complete, byte and flags valid
//   o_Rx_Byte    received data, held until the next o_Rx_DV
//   o_Parity_Err parity mismatch (always 0 when PARITY_MODE == 0)
//   o_Frame_Err  some stop bit was sampled low
//   o_Break      every data, parity and stop sample was low
//   o_Busy       receiver is not idle
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf  = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);
  localparam logic            OddPar   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone,
    StWaitIdle
  } state_e;

  state_e                 state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_s_q, rx_s_d;
  logic [CntW-1:0]        clk_cnt_q, clk_cnt_d;
  // Indexes data bits in StData and is reused as the stop-bit index in StStop.
  logic [IdxW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  // Any sample after the start bit seen high; its absence means a break.
  logic                   any_high_q, any_high_d;
  logic                   dv_q, dv_d;
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   perr_out_q, perr_out_d;
  logic                   ferr_out_q, ferr_out_d;
  logic                   brk_q, brk_d;
  logic                   busy_q, busy_d;

  logic mid_bit;
  assign mid_bit = (clk_cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    rx_meta_d  = i_Rx_Serial;
    rx_s_d     = rx_meta_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    any_high_d = any_high_q;
    dv_d       = 1'b0;
    byte_d     = byte_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    brk_d      = brk_q;

    unique case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (clk_cnt_q == CntHalf) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d    = StData;
            bit_idx_d  = '0;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
            any_high_d = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StData: begin
        if (mid_bit) begin
          clk_cnt_d  = '0;
          shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
          any_high_d = any_high_q | rx_s_q;
          if (bit_idx_q == IdxLast) begin
            bit_idx_d = '0;
            state_d   = (PARITY_MODE != 0) ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StParity: begin
        if (mid_bit) begin
          clk_cnt_d  = '0;
          par_err_d  = ((^shift_q) ^ rx_s_q) != OddPar;
          any_high_d = any_high_q | rx_s_q;
          state_d    = StStop;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (mid_bit) begin
          clk_cnt_d  = '0;
          frm_err_d  = frm_err_q | ~rx_s_q;
          any_high_d = any_high_q | rx_s_q;
          if (bit_idx_q == StopLast) begin
            state_d = StDone;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StDone: begin
        dv_d       = 1'b1;
        byte_d     = shift_q;
        perr_out_d = par_err_q;
        ferr_out_d = frm_err_q;
        brk_d      = ~any_high_q;
        // A low stop bit may be a held-low line; wait for idle so it yields one DV.
        state_d    = frm_err_q ? StWaitIdle : StIdle;
      end

      StWaitIdle: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= StIdle;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      any_high_q <= 1'b0;
      dv_q       <= 1'b0;
      byte_q     <= '0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      any_high_q <= any_high_d;
      dv_q       <= dv_d;
      byte_q     <= byte_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      brk_q      <= brk_d;
      busy_q     <= busy_d;
    end
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_out_q;
  assign o_Break      = brk_q;
  assign o_Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four instances (8N1, 8E1, 8O1, 7N2) at 16 clocks per bit,
// driven one at a time from a shared serial driver.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int   sel = 0;
  logic tx_line = 1'b1;

  logic       rx0, rx1, rx2, rx3;
  logic [7:0] byte0, byte1, byte2;
  logic [6:0] byte3;
  logic       dv_a [4];
  logic [8:0] byte_a [4];
  logic       pe_a [4];
  logic       fe_a [4];
  logic       brk_a [4];
  logic       busy_a [4];

  assign rx0 = (sel == 0) ? tx_line : 1'b1;
  assign rx1 = (sel == 1) ? tx_line : 1'b1;
  assign rx2 = (sel == 2) ? tx_line : 1'b1;
  assign rx3 = (sel == 3) ? tx_line : 1'b1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx0), .o_Rx_DV(dv_a[0]), .o_Rx_Byte(byte0),
    .o_Parity_Err(pe_a[0]), .o_Frame_Err(fe_a[0]), .o_Break(brk_a[0]), .o_Busy(busy_a[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx1), .o_Rx_DV(dv_a[1]), .o_Rx_Byte(byte1),
    .o_Parity_Err(pe_a[1]), .o_Frame_Err(fe_a[1]), .o_Break(brk_a[1]), .o_Busy(busy_a[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx2), .o_Rx_DV(dv_a[2]), .o_Rx_Byte(byte2),
    .o_Parity_Err(pe_a[2]), .o_Frame_Err(fe_a[2]), .o_Break(brk_a[2]), .o_Busy(busy_a[2]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx3), .o_Rx_DV(dv_a[3]), .o_Rx_Byte(byte3),
    .o_Parity_Err(pe_a[3]), .o_Frame_Err(fe_a[3]), .o_Break(brk_a[3]), .o_Busy(busy_a[3]));

  assign byte_a[0] = {1'b0, byte0};
  assign byte_a[1] = {1'b0, byte1};
  assign byte_a[2] = {1'b0, byte2};
  assign byte_a[3] = {2'b00, byte3};

  // Instance configuration: data bits, parity mode, stop bits.
  function automatic int nb(input int s);
    return (s == 3) ? 7 : 8;
  endfunction
  function automatic int pm(input int s);
    return (s == 1) ? 1 : (s == 2) ? 2 : 0;
  endfunction
  function automatic int sb(input int s);
    return (s == 3) ? 2 : 1;
  endfunction

  typedef struct {
    int         dut;
    logic [8:0] b;
    logic       pe;
    logic       fe;
    logic       brk;
    longint     cyc;
  } rec_t;

  rec_t q[$];

  always @(negedge clk) begin
    rec_t r;
    for (int k = 0; k < 4; k++) begin
      if (dv_a[k] === 1'b1) begin
        r.dut = k;
        r.b   = byte_a[k];
        r.pe  = pe_a[k];
        r.fe  = fe_a[k];
        r.brk = brk_a[k];
        r.cyc = longint'($time / 10);
        q.push_back(r);
      end
    end
  end

  int     total = 0;
  int     bad = 0;
  longint last_dv [4] = '{-100, -100, -100, -100};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: frame contents from plain bit arithmetic.
  function automatic void model(input int s, input logic [8:0] data, input logic par,
                                input logic [1:0] stops, output logic [8:0] eb,
                                output logic epe, output logic efe, output logic ebrk);
    int ones;
    int stop_low;
    ones = 0;
    stop_low = 0;
    eb = data & 9'((1 << nb(s)) - 1);
    for (int i = 0; i < 9; i++) ones += int'(eb[i]);
    for (int i = 0; i < sb(s); i++) if (stops[i] == 1'b0) stop_low++;
    epe  = (pm(s) != 0) && (((ones + int'(par)) % 2) != ((pm(s) == 2) ? 1 : 0));
    efe  = (stop_low != 0);
    ebrk = (eb == 9'd0) && ((pm(s) == 0) || (par == 1'b0)) && (stop_low == sb(s));
  endfunction

  task automatic send_frame(input int s, input logic [8:0] data, input logic par,
                            input logic [1:0] stops, input int idle);
    logic bits[$];
    sel = s;
    bits.push_back(1'b0);
    for (int i = 0; i < nb(s); i++) bits.push_back(data[i]);
    if (pm(s) != 0) bits.push_back(par);
    for (int i = 0; i < sb(s); i++) bits.push_back(stops[i]);
    for (int i = 0; i < idle; i++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      tx_line = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic expect_frame(input string nm, input int s, input logic [8:0] eb,
                              input logic epe, input logic efe, input logic ebrk);
    int   n;
    rec_t r;
    n = 0;
    while (q.size() == 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no DV within 64 cycles", nm);
      return;
    end
    r = q.pop_front();
    chk({nm, "_dut"}, 16'(r.dut), 16'(s));
    chk({nm, "_byte"}, 16'(r.b), 16'(eb));
    chk({nm, "_perr"}, 16'(r.pe), 16'(epe));
    chk({nm, "_ferr"}, 16'(r.fe), 16'(efe));
    chk({nm, "_brk"}, 16'(r.brk), 16'(ebrk));
    if (r.dut >= 0 && r.dut < 4) begin
      chk({nm, "_dv_gap"}, 16'(r.cyc - last_dv[r.dut] > 1), 16'd1);
      last_dv[r.dut] = r.cyc;
    end
  endtask

  typedef struct {
    int         s;
    logic [8:0] data;
    logic       par;
    logic [1:0] stops;
    logic [8:0] eb;
    logic       epe;
    logic       efe;
    logic       ebrk;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    logic saw_busy;
    logic [8:0] eb;
    logic epe, efe, ebrk;
    int s;
    logic [8:0] data;
    logic par;
    logic [1:0] stops;

    vecs.push_back('{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1, 9'h03C, 1'b1, 2'b11, 9'h03C, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{2, 9'h001, 1'b0, 2'b11, 9'h001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{0, 9'h081, 1'b0, 2'b10, 9'h081, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{0, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3, 9'h05A, 1'b0, 2'b01, 9'h05A, 1'b0, 1'b1, 1'b0});

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_dv%0d", k), 16'(dv_a[k]), 16'd0);
      chk($sformatf("rst_byte%0d", k), 16'(byte_a[k]), 16'd0);
      chk($sformatf("rst_flags%0d", k), 16'({pe_a[k], fe_a[k], brk_a[k]}), 16'd0);
      chk($sformatf("rst_busy%0d", k), 16'(busy_a[k]), 16'd0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table vectors
    foreach (vecs[i]) begin
      send_frame(vecs[i].s, vecs[i].data, vecs[i].par, vecs[i].stops, 1);
      expect_frame($sformatf("vec%0d", i), vecs[i].s, vecs[i].eb, vecs[i].epe, vecs[i].efe,
                   vecs[i].ebrk);
    end

    // Glitch on the start bit
    sel = 0;
    saw_busy = 1'b0;
    tx_line = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_busy = saw_busy | busy_a[0];
    end
    tx_line = 1'b1;
    repeat (12) begin
      @(negedge clk);
      saw_busy = saw_busy | busy_a[0];
    end
    chk("glitch_busy_seen", 16'(saw_busy), 16'd1);
    chk("glitch_busy_clear", 16'(busy_a[0]), 16'd0);
    chk("glitch_no_dv", 16'(q.size()), 16'd0);
    repeat (CPB) @(negedge clk);
    send_frame(0, 9'h055, 1'b0, 2'b11, 1);
    expect_frame("after_glitch", 0, 9'h055, 1'b0, 1'b0, 1'b0);

    // Long break
    sel = 0;
    tx_line = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    tx_line = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("break_dv_count", 16'(q.size()), 16'd1);
    expect_frame("break", 0, 9'h000, 1'b0, 1'b1, 1'b1);
    send_frame(0, 9'h055, 1'b0, 2'b11, 1);
    expect_frame("after_break", 0, 9'h055, 1'b0, 1'b0, 1'b0);

    // Reset during data bit 3 of 0x96
    sel = 0;
    tx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tx_line = (i == 0) ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
    end
    tx_line = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    chk("pre_rst_busy", 16'(busy_a[0]), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_dv", 16'(dv_a[0]), 16'd0);
    chk("midrst_byte", 16'(byte_a[0]), 16'd0);
    chk("midrst_flags", 16'({pe_a[0], fe_a[0], brk_a[0]}), 16'd0);
    chk("midrst_busy", 16'(busy_a[0]), 16'd0);
    @(negedge clk);
    tx_line = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_dv", 16'(q.size()), 16'd0);
    chk("post_rst_busy", 16'(busy_a[0]), 16'd0);
    send_frame(0, 9'h081, 1'b0, 2'b11, 1);
    expect_frame("after_rst", 0, 9'h081, 1'b0, 1'b0, 1'b0);

    // Randomized frames against the reference model
    for (int t = 0; t < 48; t++) begin
      s = int'($urandom_range(0, 3));
      data = 9'($urandom);
      par = 1'($urandom_range(0, 1));
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      if ($urandom_range(0, 7) == 0) begin
        data = 9'd0;
        par = 1'b0;
        stops = 2'b00;
      end
      model(s, data, par, stops, eb, epe, efe, ebrk);
      send_frame(s, data, par, stops, 1 + int'($urandom_range(0, 2)));
      expect_frame($sformatf("rnd%0d", t), s, eb, epe, efe, ebrk);
    end

    repeat (2 * CPB) @(negedge clk);
    chk("no_stray_dv", 16'(q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
